// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_pkg
// Description : Shared types and helpers for the convolution frame arbiter.
//               Holds the arbiter FSM state encoding and the derivation of
//               the requester-ID width used by the tag FIFO and the bus.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Width of a requester ID; a single requester still needs a 1-bit tag.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cc_frame_arbiter_if
// Description : Bus bundle for the frame arbiter.
//   req_valid/req_data/req_ready : per-requester serial sample handshake
//   up_valid/up_data             : samples forwarded to the pipeline
//   down_valid/down_data         : results returned by the pipeline
//   out_valid/out_data/out_id/out_last : tagged result stream
//   Modport slave  : arbiter side.  Modport master : environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cc_frame_arbiter_if
    import cc_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int NREQ = 4
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][XLEN-1:0]  req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       up_valid;
    logic [XLEN-1:0]            up_data;
    logic                       down_valid;
    logic [XLEN-1:0]            down_data;
    logic                       out_valid;
    logic [XLEN-1:0]            out_data;
    logic [IDW-1:0]             out_id;
    logic                       out_last;

    modport slave (
        input  req_valid, req_data, down_valid, down_data,
        output req_ready, up_valid, up_data,
               out_valid, out_data, out_id, out_last
    );

    modport master (
        output req_valid, req_data, down_valid, down_data,
        input  req_ready, up_valid, up_data,
               out_valid, out_data, out_id, out_last
    );

endinterface
`default_nettype wire

// File: rtl/cc_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cc_id_fifo
// Description : Small tag FIFO holding the requester ID of each frame that
//               is inside the pipeline. Push and pop may occur in the same
//               cycle, including when full (the popped slot is reused).
//   clk, rst (async, active-low), push/push_data, pop, full, empty, head
// Revision    : 1.0 - initial release
// ============================================================================
module cc_id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push,
    input  wire logic [W-1:0] push_data,
    input  wire logic         pop,
    output logic              full,
    output logic              empty,
    output logic [W-1:0]      head
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (r_count == CNTW'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cc_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cc_frame_arbiter
// Description : Round-robin frame arbiter in front of a convolution pipeline.
//               Grants one requester a whole WIDTH-sample frame at a time,
//               tags the returning result frames with the requester ID and
//               limits the number of frames inside the pipeline.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : cc_frame_arbiter_if.slave (request, pipeline, result streams)
//   err_orphan : sticky, a result arrived with no frame in flight
// Revision    : 1.0 - initial release
// ============================================================================
module cc_frame_arbiter
    import cc_pkg::*;
#(
    parameter int XLEN         = 16,
    parameter int WIDTH        = 128,
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cc_frame_arbiter_if.slave   bus,
    output logic                err_orphan
);
    localparam int IDW = id_width(NREQ);
    localparam int CW  = $clog2(WIDTH);

    state_t          r_state;
    state_t          w_next_state;
    logic [IDW-1:0]  r_grant;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_in_cnt;
    logic [CW-1:0]   r_out_cnt;

    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_winner;
    logic            w_found;
    logic [IDW-1:0]  w_ptr_next;
    logic [NREQ-1:0] w_req_ready;
    logic            w_up_valid;
    logic [XLEN-1:0] w_up_data;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_out_adv;
    logic            w_full;
    logic            w_empty;
    logic [IDW-1:0]  w_head;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_ptr_next = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

    // Result side: a result only advances the frame when a tag exists.
    assign w_out_adv = bus.down_valid && !w_empty;
    assign w_pop     = w_out_adv && (r_out_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_up_valid   = 1'b0;
        w_up_data    = '0;
        w_accept     = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A last result retiring this cycle frees its slot, so a
                // full FIFO can still admit when it pops at the same time.
                if (w_found && (!w_full || w_pop)) begin
                    w_push       = 1'b1;
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_req_ready[r_grant] = 1'b1;
                w_up_valid           = bus.req_valid[r_grant];
                w_up_data            = bus.req_data[r_grant];
                w_accept             = bus.req_valid[r_grant];
                if (w_accept && (r_in_cnt == CW'(WIDTH - 1))) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            err_orphan <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_push) begin
                r_grant <= w_winner;
                r_ptr   <= w_ptr_next;
            end
            if (w_accept) begin
                r_in_cnt <= (r_in_cnt == CW'(WIDTH - 1)) ? '0 : r_in_cnt + 1'b1;
            end
            if (w_out_adv) begin
                r_out_cnt <= w_pop ? '0 : r_out_cnt + 1'b1;
            end
            if (bus.down_valid && w_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    cc_id_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (IDW)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_winner),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.up_valid  = w_up_valid;
    assign bus.up_data   = w_up_data;
    assign bus.out_valid = bus.down_valid;
    assign bus.out_data  = bus.down_data;
    assign bus.out_id    = w_empty ? '0 : w_head;
    assign bus.out_last  = w_pop;

endmodule
`default_nettype wire

// File: tb/tb_cc_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_frame_arbiter
// Description : Directed self-checking bench for cc_frame_arbiter
//               (WIDTH=8, NREQ=4, MAX_INFLIGHT=2, XLEN=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_frame_arbiter;
    localparam int XLEN  = 16;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int MAXF  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_orphan;
    int   checks   = 0;
    int   failures = 0;

    cc_frame_arbiter_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();

    cc_frame_arbiter #(
        .XLEN         (XLEN),
        .WIDTH        (WIDTH),
        .NREQ         (NREQ),
        .MAX_INFLIGHT (MAXF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst            = 1'b0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.down_valid = 1'b0;
        bus.down_data  = '0;
        tick;
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst            = 1'b0;
        bus.req_valid  = 4'hF;
        bus.req_data   = '1;
        bus.down_valid = 1'b1;
        bus.down_data  = 16'hABCD;
        tick;
        checks++;
        if ({bus.req_ready, bus.up_valid, bus.up_data, bus.out_last, err_orphan} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.req_ready, bus.up_valid, bus.up_data, bus.out_last, err_orphan});
        end
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_id} !== {1'b1, 16'hABCD, 2'd0}) begin
            failures++;
            $display("FAIL reset_passthru got=%h exp=%h",
                     {bus.out_valid, bus.out_data, bus.out_id}, {1'b1, 16'hABCD, 2'd0});
        end
        bus.down_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outvalid_low got=%b exp=0", bus.out_valid);
        end
        do_reset;
    endtask

    // Requester 2 streams samples 1..8, then its result frame comes back.
    task automatic test_single;
        do_reset;
        bus.req_data[2] = 16'd1;
        bus.req_valid   = 4'b0100;
        #1;
        checks++;
        if ({bus.req_ready, bus.up_valid} !== 5'd0) begin
            failures++;
            $display("FAIL single_idle got=%b exp=0", {bus.req_ready, bus.up_valid});
        end
        tick;
        for (int k = 1; k <= 8; k++) begin
            bus.req_data[2] = 16'(k);
            #1;
            checks++;
            if ({bus.req_ready, bus.up_valid, bus.up_data} !== {4'b0100, 1'b1, 16'(k)}) begin
                failures++;
                $display("FAIL single_up[%0d] got=%h exp=%h", k,
                         {bus.req_ready, bus.up_valid, bus.up_data}, {4'b0100, 1'b1, 16'(k)});
            end
            tick;
        end
        bus.req_valid = '0;
        #1;
        checks++;
        if ({bus.req_ready, bus.up_valid} !== 5'd0) begin
            failures++;
            $display("FAIL single_done got=%b exp=0", {bus.req_ready, bus.up_valid});
        end
        for (int k = 1; k <= 8; k++) begin
            bus.down_valid = 1'b1;
            bus.down_data  = 16'(k * 3);
            #1;
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_id, bus.out_last} !==
                {1'b1, 16'(k * 3), 2'd2, (k == 8)}) begin
                failures++;
                $display("FAIL single_out[%0d] got=%h exp=%h", k,
                         {bus.out_valid, bus.out_data, bus.out_id, bus.out_last},
                         {1'b1, 16'(k * 3), 2'd2, (k == 8)});
            end
            tick;
        end
        bus.down_valid = 1'b0;
        checks++;
        if (err_orphan !== 1'b0) begin
            failures++;
            $display("FAIL single_no_orphan got=%b exp=0", err_orphan);
        end
    endtask

    // All four requesting: grants 0,1,2,3,0 with an idle cycle between frames.
    task automatic test_round_robin;
        int g;
        do_reset;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i] = 16'((i + 1) * 4096);
        end
        bus.req_valid = 4'hF;
        for (int f = 0; f < 5; f++) begin
            g = f % 4;
            #1;
            checks++;
            if ({bus.req_ready, bus.up_valid} !== 5'd0) begin
                failures++;
                $display("FAIL rr_idle[%0d] got=%b exp=0", f, {bus.req_ready, bus.up_valid});
            end
            tick;
            for (int j = 0; j < WIDTH; j++) begin
                if (f > 0) begin
                    bus.down_valid = 1'b1;
                    bus.down_data  = 16'(j);
                end
                #1;
                checks++;
                if ({bus.req_ready, bus.up_data} !== {4'(1 << g), 16'((g + 1) * 4096)}) begin
                    failures++;
                    $display("FAIL rr_grant[%0d.%0d] got=%h exp=%h", f, j,
                             {bus.req_ready, bus.up_data}, {4'(1 << g), 16'((g + 1) * 4096)});
                end
                if (f > 0) begin
                    checks++;
                    if ({bus.out_id, bus.out_last} !== {2'((f - 1) % 4), (j == 7)}) begin
                        failures++;
                        $display("FAIL rr_tag[%0d.%0d] got=%b exp=%b", f, j,
                                 {bus.out_id, bus.out_last}, {2'((f - 1) % 4), (j == 7)});
                    end
                end
                tick;
            end
            bus.down_valid = 1'b0;
        end
        bus.req_valid = '0;
        for (int j = 0; j < WIDTH; j++) begin
            bus.down_valid = 1'b1;
            #1;
            checks++;
            if ({bus.out_id, bus.out_last} !== {2'd0, (j == 7)}) begin
                failures++;
                $display("FAIL rr_drain[%0d] got=%b exp=%b", j,
                         {bus.out_id, bus.out_last}, {2'd0, (j == 7)});
            end
            tick;
        end
        bus.down_valid = 1'b0;
    endtask

    // Two frames in flight block the third until the first retires; the
    // retiring last result and the new grant share a cycle.
    task automatic test_fifo_full;
        do_reset;
        bus.req_valid = 4'b0011;
        for (int f = 0; f < 2; f++) begin
            tick;
            for (int j = 0; j < WIDTH; j++) begin
                #1;
                checks++;
                if (bus.req_ready !== 4'(1 << f)) begin
                    failures++;
                    $display("FAIL full_fill[%0d.%0d] got=%b exp=%b", f, j,
                             bus.req_ready, 4'(1 << f));
                end
                tick;
            end
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL full_block[%0d] got=%b exp=0000", c, bus.req_ready);
            end
            tick;
        end
        for (int j = 0; j < WIDTH; j++) begin
            bus.down_valid = 1'b1;
            #1;
            checks++;
            if ({bus.req_ready, bus.out_id, bus.out_last} !== {4'b0000, 2'd0, (j == 7)}) begin
                failures++;
                $display("FAIL full_retire_a[%0d] got=%b exp=%b", j,
                         {bus.req_ready, bus.out_id, bus.out_last}, {4'b0000, 2'd0, (j == 7)});
            end
            tick;
        end
        bus.down_valid = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            #1;
            checks++;
            if (bus.req_ready !== 4'b0001) begin
                failures++;
                $display("FAIL full_regrant[%0d] got=%b exp=0001", j, bus.req_ready);
            end
            tick;
        end
        bus.req_valid = '0;
        for (int j = 0; j < 2 * WIDTH; j++) begin
            bus.down_valid = 1'b1;
            #1;
            checks++;
            if ({bus.out_id, bus.out_last} !== {((j < WIDTH) ? 2'd1 : 2'd0), (j % WIDTH == 7)}) begin
                failures++;
                $display("FAIL full_tags[%0d] got=%b exp=%b", j, {bus.out_id, bus.out_last},
                         {((j < WIDTH) ? 2'd1 : 2'd0), (j % WIDTH == 7)});
            end
            tick;
        end
        bus.down_valid = 1'b0;
    endtask

    // Result with nothing in flight: sticky error, tag 0, counter untouched.
    task automatic test_orphan;
        do_reset;
        bus.down_valid = 1'b1;
        bus.down_data  = 16'h5A5A;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_id, bus.out_last, err_orphan} !== 5'b1_00_0_0) begin
            failures++;
            $display("FAIL orphan_pre got=%b exp=10000",
                     {bus.out_valid, bus.out_id, bus.out_last, err_orphan});
        end
        tick;
        bus.down_valid = 1'b0;
        #1;
        checks++;
        if (err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_set got=%b exp=1", err_orphan);
        end
        tick;
        tick;
        checks++;
        if (err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_sticky got=%b exp=1", err_orphan);
        end
        bus.req_valid = 4'b1000;
        tick;
        for (int j = 0; j < WIDTH; j++) begin
            tick;
        end
        bus.req_valid = '0;
        for (int j = 0; j < WIDTH; j++) begin
            bus.down_valid = 1'b1;
            #1;
            checks++;
            if ({bus.out_id, bus.out_last, err_orphan} !== {2'd3, (j == 7), 1'b1}) begin
                failures++;
                $display("FAIL orphan_frame[%0d] got=%b exp=%b", j,
                         {bus.out_id, bus.out_last, err_orphan}, {2'd3, (j == 7), 1'b1});
            end
            tick;
        end
        bus.down_valid = 1'b0;
    endtask

    // Reset after 3 of 8 samples: frame abandoned, pointer and counter restart.
    task automatic test_reset_midframe;
        do_reset;
        bus.req_valid = 4'b0010;
        tick;
        for (int j = 0; j < 3; j++) begin
            tick;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.up_valid} !== 5'd0) begin
            failures++;
            $display("FAIL midrst_ready got=%b exp=0", {bus.req_ready, bus.up_valid});
        end
        tick;
        rst           = 1'b1;
        bus.req_valid = 4'b1010;
        tick;
        for (int j = 0; j < WIDTH; j++) begin
            #1;
            checks++;
            if ({bus.req_ready, bus.up_valid} !== {4'b0010, 1'b1}) begin
                failures++;
                $display("FAIL midrst_frame[%0d] got=%b exp=%b", j,
                         {bus.req_ready, bus.up_valid}, {4'b0010, 1'b1});
            end
            tick;
        end
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_end got=%b exp=0000", bus.req_ready);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_fifo_full;
        test_orphan;
        test_reset_midframe;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
`default_nettype wire
